// File: rtl/seq_gen_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_gen_tx
//  Purpose  : Framed serial transmitter. Accepts one payload byte, then
//             emits a 7-bit sync pattern (MSB first), the byte (MSB first),
//             an optional even-parity bit, and GAP_CYCLES idle bit-times.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk        in   1  clock, all logic on posedge
//    rst        in   1  asynchronous active-high reset
//    data_in    in   8  payload byte
//    data_valid in   1  payload offered
//    data_ready out  1  block can accept a payload (IDLE only)
//    seq_out    out  1  serial bit stream (0 when seq_vld is 0)
//    seq_vld    out  1  seq_out carries a frame bit
//    busy       out  1  frame in progress (SYNC/DATA/PAR/GAP)
//    done       out  1  one-cycle pulse on the last frame bit
//
//  Build option
//    SEQ_GEN_PARITY_EN  when defined, a PAR state appends an even-parity
//                       bit after the payload (16-bit frame); otherwise the
//                       frame is 15 bits and done lands on payload bit 0.
// ============================================================================
module seq_gen_tx #(
  parameter logic [6:0] SYNC_PAT   = 7'b1011010,
  parameter int         GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       seq_out,
  output logic       seq_vld,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef SEQ_GEN_PARITY_EN
  localparam logic [2:0] S_PAR  = 3'd3;
`endif
  localparam logic [2:0] S_GAP  = 3'd4;

  // The gap counter is loaded with GAP_CYCLES-1 so GAP lasts exactly
  // GAP_CYCLES cycles; with GAP_CYCLES=0 the GAP state is never entered.
  localparam logic       GAP_EN   = (GAP_CYCLES > 0);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [2:0] state_q,   state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] byte_q,    byte_d;
  logic       seq_out_q, seq_out_d;
  logic       seq_vld_q, seq_vld_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       frame_end;

  // state_q names the state whose bit is currently on seq_out; the output
  // registers are loaded from the next-state values so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      byte_q    <= 8'd0;
      seq_out_q <= 1'b0;
      seq_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      byte_q    <= byte_d;
      seq_out_q <= seq_out_d;
      seq_vld_q <= seq_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    byte_d    = byte_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d   = S_SYNC;
          bit_cnt_d = 3'd6;
          byte_d    = data_in;
        end
      end
      S_SYNC: begin
        if (bit_cnt_q == 3'd0) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd7;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 3'd0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        frame_end = 1'b1;
      end
`endif
      S_GAP: begin
        // Leaving at zero means the counter never wraps below 0.
        if (gap_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (frame_end) begin
      if (GAP_EN) begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_LOAD;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Output logic, decoded from the state being entered
  always_comb begin
    seq_out_d = 1'b0;
    seq_vld_d = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_SYNC: begin
        seq_vld_d = 1'b1;
        seq_out_d = SYNC_PAT[bit_cnt_d];
      end
      S_DATA: begin
        seq_vld_d = 1'b1;
        seq_out_d = byte_d[bit_cnt_d];
`ifndef SEQ_GEN_PARITY_EN
        done_d    = (bit_cnt_d == 3'd0);
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        seq_vld_d = 1'b1;
        seq_out_d = ^byte_d;
        done_d    = 1'b1;
      end
`endif
      default: begin
        seq_vld_d = 1'b0;
      end
    endcase
  end

  // Ready is a pure state decode, masked while reset is held.
  assign data_ready = (state_q == S_IDLE) && !rst;
  assign seq_out    = seq_out_q;
  assign seq_vld    = seq_vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_gen_tx
//  Purpose  : Self-checking bench for seq_gen_tx. Two instances: GAP_CYCLES=2
//             (index 0) and GAP_CYCLES=0 (index 1). Expected frames are
//             built from the frame definition (sync pattern, payload MSB
//             first, optional even parity, idle gap) and compared per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen_tx;

`ifdef SEQ_GEN_PARITY_EN
  localparam int FLEN = 16;
`else
  localparam int FLEN = 15;
`endif

  logic       clk;
  logic       rst;
  logic       dv  [2];
  logic [7:0] din [2];
  logic       rdy [2];
  logic       so  [2];
  logic       sv  [2];
  logic       bz  [2];
  logic       dn  [2];
  logic [6:0] det [2];

  int n_tests;
  int n_fail;

  seq_gen_tx #(.SYNC_PAT(7'b1011010), .GAP_CYCLES(2)) u_gap2 (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .seq_out(so[0]), .seq_vld(sv[0]), .busy(bz[0]), .done(dn[0])
  );

  seq_gen_tx #(.SYNC_PAT(7'b1011010), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .seq_out(so[1]), .seq_vld(sv[1]), .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic       hold;
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame on instance sel and checks every cycle through the
  // following IDLE cycle. With hold=1 data_valid stays high for the whole
  // frame and the next call re-raises it at once, i.e. valid is continuous.
  task automatic run_frame(input int sel, input logic [7:0] d, input logic hold,
                           input logic par);
    logic exp [FLEN];
    logic [6:0] sync;
    int gap;
    int waitc;
    int flags;
    int fpos;
    sync  = 7'b1011010;
    gap   = (sel == 0) ? 2 : 0;
    waitc = 0;
    flags = 0;
    fpos  = -1;
    for (int i = 0; i < 7; i++) exp[i] = sync[6 - i];
    for (int i = 0; i < 8; i++) exp[7 + i] = d[7 - i];
    if (FLEN == 16) exp[FLEN - 1] = par;
    det[sel] = 7'd0;

    while (!rdy[sel] && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    chk($sformatf("ready_start[%0d] d=%02h", sel, d), 32'(rdy[sel]), 32'd1);
    dv[sel]  = 1'b1;
    din[sel] = d;
    @(negedge clk);
    dv[sel] = hold;
    for (int i = 0; i < FLEN; i++) begin
      din[sel] = 8'($urandom);
      chk($sformatf("frame[%0d] d=%02h bit%0d {rdy,busy,vld,done,out}", sel, d, i),
          32'({rdy[sel], bz[sel], sv[sel], dn[sel], so[sel]}),
          32'({1'b0, 1'b1, 1'b1, (i == FLEN - 1), exp[i]}));
      if (sv[sel]) begin
        det[sel] = {det[sel][5:0], so[sel]};
        if (det[sel] == 7'b1011010) begin
          flags++;
          fpos = i;
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < gap; g++) begin
      chk($sformatf("gap[%0d] d=%02h g%0d", sel, d, g),
          32'({rdy[sel], bz[sel], sv[sel], dn[sel], so[sel]}), 32'b01000);
      @(negedge clk);
    end
    dv[sel] = 1'b0;
    chk($sformatf("idle[%0d] d=%02h {rdy,busy,vld,out}", sel, d),
        32'({rdy[sel], bz[sel], sv[sel], so[sel]}), 32'b1000);
    if (d == 8'h00) begin
      chk($sformatf("loop_flags[%0d]", sel), 32'(flags), 32'd1);
      chk($sformatf("loop_pos[%0d]", sel), 32'(fpos), 32'd6);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    logic [7:0] rd;
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{0, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{0, 1'b0, 8'h07, 1'b1};
    vecs[2] = '{0, 1'b0, 8'h03, 1'b0};
    vecs[3] = '{0, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{0, 1'b1, 8'hC3, 1'b0};
    vecs[5] = '{0, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1, 1'b1, 8'h81, 1'b0};
    vecs[8] = '{1, 1'b0, 8'hFE, 1'b1};
    vecs[9] = '{0, 1'b1, 8'h00, 1'b0};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      dv[s]  = 1'b1;
      din[s] = 8'hFF;
      det[s] = 7'd0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset[%0d] {rdy,busy,vld,done,out}", s),
          32'({rdy[s], bz[s], sv[s], dn[s], so[s]}), 32'd0);
      dv[s] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) run_frame(vecs[k].sel, vecs[k].data, vecs[k].hold, vecs[k].exp_par);

    // Reset in the middle of DATA abandons the frame.
    dv[0]  = 1'b1;
    din[0] = 8'h5A;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_in_data {busy,vld}", 32'({bz[0], sv[0]}), 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("midreset {rdy,busy,vld,done,out}",
        32'({rdy[0], bz[0], sv[0], dn[0], so[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset ready", 32'(rdy[0]), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("no_residual c%0d {busy,vld,done}", c),
          32'({bz[0], sv[0], dn[0]}), 32'd0);
    end
    run_frame(0, 8'h96, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      rd = 8'($urandom);
      run_frame(int'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), ^rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
